mdu_sequencer: RTL and testbench



---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_div_iter.sv | 55 +++++
 rtl/mdu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the M-extension unit and its sequencer.
package mdu_pkg;

   localparam int unsigned MDU_XLEN = 32;
   localparam int unsigned DIV_ITER = MDU_XLEN;

   localparam logic [MDU_XLEN-1:0] DIV_BY_ZERO_Q = '1;
   localparam logic [MDU_XLEN-1:0] SIGNED_MIN    = {1'b1, {(MDU_XLEN-1){1'b0}}};

   typedef enum logic [3:0] {
      MduMul    = 4'd0,
      MduMulh   = 4'd1,
      MduMulhsu = 4'd2,
      MduMulhu  = 4'd3,
      MduDiv    = 4'd4,
      MduDivu   = 4'd5,
      MduRem    = 4'd6,
      MduRemu   = 4'd7
   } risk_mdu_e;

   typedef struct packed {
      logic      enable;
      risk_mdu_e operation;
   } mdu_control_t;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2,
      StDone = 2'd3
   } mdu_seq_state_e;

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step.
// Outputs show the quotient/remainder as they will be after the current step.
module mdu_div_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic            step_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);

   logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [XLEN-1:0] quo_step, rem_step;
   logic [XLEN:0]   trial, diff;

   always_comb begin
      trial    = {rem_q, quo_q[XLEN-1]};
      diff     = trial - {1'b0, dvs_q};
      // diff[XLEN] set means the trial subtraction borrowed: restore
      quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};
      rem_step = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];

      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      if (start_i) begin
         quo_d = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
      end else if (step_i) begin
         quo_d = quo_step;
         rem_d = rem_step;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

   assign quotient_o  = quo_step;
   assign remainder_o = rem_step;

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/DIV/REM controller with valid/ready result handshake and flush.
// Optional: define MDU_DIV_EARLY_EXIT_EN to finish |dividend| < |divisor| divides at once.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int unsigned XLEN = MDU_XLEN
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   input  mdu_control_t    i_mdu_control,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic [4:0]      i_rd,
   input  logic            i_flush,
   input  logic            i_ready,
   output logic            o_ready,
   output logic            o_stall,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result,
   output logic [4:0]      o_rd
);

   localparam int unsigned CntW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SignedMin = {1'b1, {(XLEN-1){1'b0}}};

   mdu_seq_state_e  state_q, state_d;
   risk_mdu_e       op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic [4:0]      rd_q, rd_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, is_rem_q, is_rem_d;

   logic            accept, is_mul, is_div, div_signed, div_rem, div_start;
   logic [XLEN-1:0] mag_a, mag_b, div_quo, div_rem_mag, fix_quo, fix_rem;
   logic            mul_sa, mul_sb;
   logic [2*XLEN-1:0] ext_a, ext_b, prod;

   mdu_div_iter #(
      .XLEN (XLEN)
   ) u_div_iter (
      .clk_i       (i_clk),
      .rst_ni      (i_rst_n),
      .start_i     (div_start),
      .step_i      (state_q == StDiv),
      .dividend_i  (mag_a),
      .divisor_i   (mag_b),
      .quotient_o  (div_quo),
      .remainder_o (div_rem_mag)
   );

   always_comb begin
      is_mul     = 1'b0;
      is_div     = 1'b0;
      div_signed = 1'b0;
      div_rem    = 1'b0;
      case (i_mdu_control.operation)
         MduMul, MduMulh, MduMulhsu, MduMulhu: is_mul = 1'b1;
         MduDiv:  begin is_div = 1'b1; div_signed = 1'b1; end
         MduDivu: is_div = 1'b1;
         MduRem:  begin is_div = 1'b1; div_signed = 1'b1; div_rem = 1'b1; end
         MduRemu: begin is_div = 1'b1; div_rem = 1'b1; end
         default: ;
      endcase

      accept = i_valid & i_mdu_control.enable & (state_q == StIdle) & ~i_flush;
      mag_a  = (div_signed & i_op_a[XLEN-1]) ? -i_op_a : i_op_a;
      mag_b  = (div_signed & i_op_b[XLEN-1]) ? -i_op_b : i_op_b;

      mul_sa = (op_q == MduMulh) || (op_q == MduMulhsu);
      mul_sb = (op_q == MduMulh);
      ext_a  = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
      ext_b  = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
      prod   = ext_a * ext_b;

      fix_quo = neg_quo_q ? -div_quo : div_quo;
      fix_rem = neg_rem_q ? -div_rem_mag : div_rem_mag;
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      result_d  = result_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      is_rem_d  = is_rem_q;
      div_start = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept && (is_mul || is_div)) begin
               op_d      = i_mdu_control.operation;
               a_d       = i_op_a;
               b_d       = i_op_b;
               rd_d      = i_rd;
               cnt_d     = '0;
               neg_quo_d = div_signed & (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
               neg_rem_d = div_signed & i_op_a[XLEN-1];
               is_rem_d  = div_rem;
               if (is_mul) begin
                  state_d = StMul;
               end else if (i_op_b == '0) begin
                  state_d  = StDone;
                  result_d = div_rem ? i_op_a : '1;
               end else if (div_signed && (i_op_a == SignedMin) && (i_op_b == '1)) begin
                  state_d  = StDone;
                  result_d = div_rem ? '0 : SignedMin;
`ifdef MDU_DIV_EARLY_EXIT_EN
               end else if (mag_a < mag_b) begin
                  state_d  = StDone;
                  result_d = div_rem ? i_op_a : '0;
`endif
               end else begin
                  state_d   = StDiv;
                  div_start = 1'b1;
               end
            end
         end
         StMul: begin
            result_d = (op_q == MduMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            state_d  = StDone;
         end
         StDiv: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(XLEN - 1)) begin
               state_d  = StDone;
               result_d = is_rem_q ? fix_rem : fix_quo;
            end
         end
         StDone: begin
            if (i_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Flush wins over accept, completion and the writeback handshake
      if (i_flush) state_d = StIdle;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         op_q      <= MduMul;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_rem_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         result_q  <= result_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         is_rem_q  <= is_rem_d;
      end
   end

   assign o_ready  = (state_q == StIdle);
   assign o_stall  = (state_q != StIdle);
   assign o_valid  = (state_q == StDone);
   assign o_result = result_q;
   assign o_rd     = rd_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed vector bench for mdu_sequencer, plus handshake, flush and reset sequences.
module tb_mdu_sequencer;
   import mdu_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid, i_flush, i_ready;
   mdu_control_t ctrl;
   logic [31:0]  op_a, op_b;
   logic [4:0]   rd;
   logic         o_ready, o_stall, o_valid;
   logic [31:0]  o_result;
   logic [4:0]   o_rd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mdu_sequencer #(
      .XLEN (32)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_valid       (i_valid),
      .i_mdu_control (ctrl),
      .i_op_a        (op_a),
      .i_op_b        (op_b),
      .i_rd          (rd),
      .i_flush       (i_flush),
      .i_ready       (i_ready),
      .o_ready       (o_ready),
      .o_stall       (o_stall),
      .o_valid       (o_valid),
      .o_result      (o_result),
      .o_rd          (o_rd)
   );

`ifdef MDU_DIV_EARLY_EXIT_EN
   localparam int EarlyLat = 1;
`else
   localparam int EarlyLat = 33;
`endif

   typedef struct {
      risk_mdu_e   op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NVec = 18;
   vec_t vecs[NVec];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic issue(input risk_mdu_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst);
      @(negedge clk);
      i_valid        = 1'b1;
      ctrl.enable    = 1'b1;
      ctrl.operation = op;
      op_a           = a;
      op_b           = b;
      rd             = dst;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   // Returns the cycle (relative to the accept edge T) at which o_valid is first seen
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!o_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int seen;
      logic [31:0] held;

      vecs[0]  = '{MduMulh,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 2};
      vecs[1]  = '{MduMulhu,  32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 2};
      vecs[2]  = '{MduMul,    32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 2};
      vecs[3]  = '{MduMulhsu, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 2};
      vecs[4]  = '{MduMulh,   32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
      vecs[5]  = '{MduDiv,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
      vecs[6]  = '{MduRem,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
      vecs[7]  = '{MduDivu,   32'd100,       32'd7,         32'd14,        33};
      vecs[8]  = '{MduRemu,   32'd100,       32'd7,         32'd2,         33};
      vecs[9]  = '{MduDiv,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[10] = '{MduRem,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[11] = '{MduDivu,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};
      vecs[12] = '{MduDivu,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[13] = '{MduRem,    32'd5,         32'd0,         32'd5,         1};
      vecs[14] = '{MduDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[15] = '{MduRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[16] = '{MduDiv,    32'd3,         32'd10,        32'd0,         EarlyLat};
      vecs[17] = '{MduRem,    32'hFFFF_FFFD, 32'd10,        32'hFFFF_FFFD, EarlyLat};

      rst_n          = 1'b0;
      i_valid        = 1'b0;
      i_flush        = 1'b0;
      i_ready        = 1'b0;
      ctrl.enable    = 1'b0;
      ctrl.operation = MduMul;
      op_a           = '0;
      op_b           = '0;
      rd             = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset o_valid", {31'b0, o_valid}, 32'd0);
      check("reset o_ready", {31'b0, o_ready}, 32'd1);
      check("reset o_stall", {31'b0, o_stall}, 32'd0);
      check("reset o_result", o_result, 32'd0);
      check("reset o_rd", {27'b0, o_rd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVec; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1));
         wait_valid(lat);
         check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d result", i), o_result, vecs[i].exp);
         check($sformatf("vec%0d rd", i), {27'b0, o_rd}, 32'(i + 1));
         check($sformatf("vec%0d ready in done", i), {31'b0, o_ready}, 32'd0);
         release_result();
         check($sformatf("vec%0d idle after ack", i), {30'b0, o_valid, o_ready}, 32'd1);
      end

      // Backpressure: result must hold and a new request must be ignored
      issue(MduMul, 32'd6, 32'd7, 5'd9);
      wait_valid(lat);
      check("bp latency", lat, 2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         i_valid        = 1'b1;
         ctrl.enable    = 1'b1;
         ctrl.operation = MduDivu;
         op_a           = 32'd50;
         op_b           = 32'd3;
         rd             = 5'd20;
         @(posedge clk);
         #1;
         check($sformatf("bp hold%0d valid", c), {31'b0, o_valid}, 32'd1);
         check($sformatf("bp hold%0d result", c), o_result, 32'd42);
         check($sformatf("bp hold%0d rd", c), {27'b0, o_rd}, 32'd9);
         check($sformatf("bp hold%0d ready", c), {31'b0, o_ready}, 32'd0);
      end
      @(negedge clk);
      i_valid = 1'b0;
      release_result();
      check("bp idle after ack", {29'b0, o_valid, o_ready, o_stall}, 32'd2);

      // Flush at T+10 of a divide
      issue(MduDivu, 32'd100, 32'd7, 5'd3);
      seen = 0;
      for (int c = 0; c < 9; c++) begin
         @(posedge clk);
         #1;
         if (o_valid || !o_stall) seen++;
      end
      check("flush pre busy", seen, 0);
      @(negedge clk);
      i_flush = 1'b1;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
      check("flush idle", {29'b0, o_valid, o_ready, o_stall}, 32'd2);
      seen = 0;
      for (int c = 0; c < 35; c++) begin
         @(posedge clk);
         #1;
         if (o_valid) seen++;
      end
      check("flush no valid", seen, 0);

      // Flush beats accept in the same cycle
      @(negedge clk);
      i_valid        = 1'b1;
      i_flush        = 1'b1;
      ctrl.enable    = 1'b1;
      ctrl.operation = MduMul;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_flush = 1'b0;
      check("flush vs accept", {31'b0, o_stall}, 32'd0);

      // enable=0 and undefined encodings are ignored
      @(negedge clk);
      i_valid        = 1'b1;
      ctrl.enable    = 1'b0;
      ctrl.operation = MduDivu;
      @(posedge clk);
      #1;
      check("enable low ignored", {31'b0, o_stall}, 32'd0);
      @(negedge clk);
      ctrl.enable    = 1'b1;
      ctrl.operation = risk_mdu_e'(4'hF);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      check("undefined op ignored", {31'b0, o_stall}, 32'd0);

      // Reset mid-divide; o_result/o_rd are nonzero from the earlier multiply
      issue(MduDivu, 32'd1000, 32'd3, 5'd17);
      repeat (5) @(posedge clk);
      held = o_result;
      check("pre-reset result", held, 32'd42);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst state", {29'b0, o_valid, o_ready, o_stall}, 32'd2);
      check("midrst result", o_result, 32'd0);
      check("midrst rd", {27'b0, o_rd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 35; c++) begin
         @(posedge clk);
         #1;
         if (o_valid) seen++;
      end
      check("midrst no valid", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
